ram_burst_reader: RTL and testbench

- Read-side master for the 1R1W synchronous-read RAM (AW-bit address, DW-bit data, 1-cycle read latency, same-cycle write bypass inside the RAM).
- Accepts a burst request (start address, beat count) and issues sequential read addresses to the RAM port.
- Absorbs the read latency and delivers beats on a valid/ready stream with a last flag.
- Used by cache writeback and line-transfer paths to stream RAM contents into a backpressured consumer.

---
 rtl/ram_burst_reader_pkg.sv | 14 +
 rtl/ram_burst_reader_sync_fifo_2.sv | 55 +++++
 rtl/ram_burst_reader.sv | 109 ++++++++++
 tb/tb_ram_burst_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// rtl/ram_burst_reader_pkg.sv - shared state encoding and default widths for the RAM burst reader
package ram_burst_reader_pkg;

    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 64;
    localparam int DEF_LENW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_reader_sync_fifo_2.sv
// rtl/ram_burst_reader_sync_fifo_2.sv - two-entry synchronous FIFO with occupancy count
module sync_fifo_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign pop_data = mem[rd_ptr];
    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - streams a sequential burst out of a 1-cycle-latency RAM onto a valid/ready port
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int LENW = DEF_LENW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [LENW-1:0] req_len,
    output logic [AW-1:0]   ram_raddr,
    input  logic [DW-1:0]   ram_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            busy
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LENW:0] CNT_ONE  = {{LENW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] raddr_hold;
    logic [LENW:0] issue_cnt;
    logic          inflight;
    logic          inflight_last;

    logic [1:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    credit;
    logic          pop;
    logic          push;
    logic          issue;
    logic          final_issue;

    assign req_ready   = rst && (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign push        = inflight && (!fifo_full || pop);

    // Credit covers both buffered beats and the one read still in the RAM pipeline.
    assign credit      = fifo_count + {1'b0, inflight};
    assign issue       = rst && (state == ST_ISSUE) &&
                         ((credit < 2'd2) || ((credit == 2'd2) && pop));
    assign final_issue = issue && (issue_cnt == CNT_ONE);
    assign ram_raddr   = issue ? addr_q : raddr_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            raddr_hold    <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= final_issue;
            if (issue) begin
                raddr_hold <= addr_q;
                addr_q     <= addr_q + ADDR_ONE;
                issue_cnt  <= issue_cnt - CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        issue_cnt <= {1'b0, req_len} + CNT_ONE;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (final_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo_2 #(
        .W(DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({inflight_last, ram_rd}),
        .pop       (pop),
        .pop_data  ({out_last, out_data}),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - directed self-checking bench for ram_burst_reader with a bypassing RAM model
module tb_ram_burst_reader;

    localparam int AW   = 10;
    localparam int DW   = 64;
    localparam int LENW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic [LENW-1:0] req_len;
    logic [AW-1:0]   ram_raddr;
    logic [DW-1:0]   ram_rd;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata;
    bit   [DW-1:0]   mem [1 << AW];
    bit              written [1 << AW];

    int checks   = 0;
    int failures = 0;
    int first_cyc;
    int last_cyc;

    always #5 clk = ~clk;

    ram_burst_reader #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .ram_raddr (ram_raddr),
        .ram_rd    (ram_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16'hC0DE, 6'd0, a, 16'h5A00, 6'd0, a};
    endfunction

    // Synchronous-read RAM with same-cycle write bypass.
    always @(posedge clk) begin
        if (ram_we && ram_waddr == ram_raddr) ram_rd <= ram_wdata;
        else if (written[ram_raddr])          ram_rd <= mem[ram_raddr];
        else                                  ram_rd <= pat(ram_raddr);
        if (ram_we) begin
            mem[ram_waddr]     <= ram_wdata;
            written[ram_waddr] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic request(input logic [AW-1:0] a, input logic [LENW-1:0] l);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_accept", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect(input logic [AW-1:0] a, input logic [LENW-1:0] l, input logic [15:0] rpat,
                           input int stop, input logic wen, input logic [AW-1:0] waddr,
                           input logic [DW-1:0] wdata, input string tag,
                           output int fc, output int lc);
        int beat = 0;
        int issued = 0;
        int cyc = 0;
        int lim;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        logic [AW-1:0] cur;
        logic [DW-1:0] exp_d;
        lim = (stop < int'(l) + 1) ? stop : int'(l) + 1;
        fc = -1;
        lc = -1;
        while (beat < lim && cyc < 300) begin
            out_ready = rpat[cyc % 16];
            ram_we    = 1'b0;
            #1;
            check({tag, "_req_ready_busy"}, req_ready, 1'b0);
            if (issued <= int'(l) && ram_raddr == a + issued[AW-1:0]) begin
                if (wen && ram_raddr == waddr) begin
                    ram_we    = 1'b1;
                    ram_waddr = waddr;
                    ram_wdata = wdata;
                end
                issued++;
            end
            if (stalled) check({tag, "_stable"}, out_data, held);
            if (out_valid && out_ready) begin
                cur   = a + beat[AW-1:0];
                exp_d = (wen && cur == waddr) ? wdata : pat(cur);
                check({tag, "_data"}, out_data, exp_d);
                check({tag, "_last"}, out_last, (beat == int'(l)));
                if (fc < 0) fc = cyc;
                lc = cyc;
                beat++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
            check({tag, "_outstanding"}, (issued - beat) > 2, 1'b0);
            @(negedge clk);
            cyc++;
        end
        ram_we = 1'b0;
        check({tag, "_beats"}, beat, lim);
        if (beat == int'(l) + 1) check({tag, "_issued"}, issued, int'(l) + 1);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_raddr", ram_raddr, 10'h000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1'b1);

        // Single beat: address in cycle 1, beat in cycle 3.
        request(10'd5, 8'd0);
        #1;
        check("single_raddr", ram_raddr, 10'd5);
        check("single_busy", busy, 1'b1);
        collect(10'd5, 8'd0, 16'hFFFF, 1000, 1'b0, '0, '0, "single", first_cyc, last_cyc);
        check("single_latency", first_cyc, 2);
        #1;
        check("single_busy_after", busy, 1'b0);
        check("single_ready_after", req_ready, 1'b1);

        // Address wrap, full rate.
        request(10'h3FE, 8'd3);
        collect(10'h3FE, 8'd3, 16'hFFFF, 1000, 1'b0, '0, '0, "wrap", first_cyc, last_cyc);
        check("wrap_rate", last_cyc - first_cyc, 3);

        // Backpressure pattern 1,0,0,1,0,1,1,1,...
        request(10'h100, 8'd7);
        collect(10'h100, 8'd7, 16'hFFE9, 1000, 1'b0, '0, '0, "bp", first_cyc, last_cyc);
        #1;
        check("bp_busy_after", busy, 1'b0);

        // Second request pending during a burst.
        request(10'h020, 8'd3);
        req_valid = 1'b1;
        req_addr  = 10'h040;
        req_len   = 8'd1;
        collect(10'h020, 8'd3, 16'hFFFF, 1000, 1'b0, '0, '0, "busyA", first_cyc, last_cyc);
        #1;
        check("busy_ready_return", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        collect(10'h040, 8'd1, 16'hFFFF, 1000, 1'b0, '0, '0, "busyB", first_cyc, last_cyc);

        // Reset after two beats of eight.
        request(10'h080, 8'd7);
        collect(10'h080, 8'd7, 16'hFFFF, 2, 1'b0, '0, '0, "rstmid", first_cyc, last_cyc);
        rst = 1'b0;
        #1;
        check("rstmid_req_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_raddr", ram_raddr, 10'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstmid_no_stale", out_valid, 1'b0);
        end
        request(10'h010, 8'd1);
        collect(10'h010, 8'd1, 16'hFFFF, 1000, 1'b0, '0, '0, "postrst", first_cyc, last_cyc);

        // Write to the address in the cycle it is issued.
        request(10'h200, 8'd3);
        collect(10'h200, 8'd3, 16'hFFFF, 1000, 1'b1, 10'h202, 64'hDEADBEEF_CAFEF00D, "bypass",
                first_cyc, last_cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
